cbuf_acq_sequencer: RTL and testbench
=====================================

// Module: cbuf_acq_sequencer
// PURPOSE
// Sequences one channel's circular-buffer acquisition. ADC sample blocks are written into the DDR3 ring at
// wrapping addresses, with a programmable pre-trigger fill and post-trigger length. After the post-trigger
// writes drain, acq_done is raised. Sits between the ADC block FIFO (blk_valid) and the DDR3 write port.
// PARAMETERS
// AW     20  ring address width in blocks; the ring depth is 2**AW and addresses wrap modulo 2**AW
// LEN_W  20  width of pre_len/post_len (number of blocks)
// PORTS
// clk        in   1      channel clock; all logic is synchronous to it
// reset_n    in   1      asynchronous, active-low reset
// arm        in   1      1-cycle pulse: start an acquisition (acted on only in IDLE or DONE)
// abort      in   1      1-cycle pulse: cancel the acquisition in progress
// acq_trig   in   1      trigger level, already synchronous to clk; the rising edge is used
// pre_len    in   LEN_W  pre-trigger blocks; sampled on arm
// post_len   in   LEN_W  post-trigger blocks; sampled on arm
// blk_valid  in   1      1-cycle pulse: one ADC block is ready to store
// wr_req     out  1      DDR3 block write request
// wr_addr    out  AW     ring address of the requested block
// wr_ack     in   1      DDR3 accepted the request; only meaningful while wr_req=1
// acq_done   out  1      acquisition complete; held until arm/abort
// busy       out  1      1 in any state except IDLE and DONE
// trig_addr  out  AW     ring address of the first post-trigger block
// overrun    out  1      sticky: a block was dropped; cleared by arm
// state      out  3      IDLE=0 FILL=1 ARMED=2 POST=3 DRAIN=4 DONE=5
// BEHAVIOUR
// - Reset (async, reset_n=0): every output is 0, state=IDLE, acc_ptr=0, pending slot empty, counters 0.
//   wr_req drops immediately.
// - Accept a block: blk_valid=1 in FILL, ARMED or POST. Otherwise blk_valid is ignored and not counted.
// - On acceptance the block takes address acc_ptr, then acc_ptr increments (wrapping).
// - Write path holds one outstanding request plus a 1-deep pending slot.
//   - If no request is outstanding (or it is acked this cycle) and the slot is empty, a block accepted in
//     cycle N gives wr_req=1 with wr_addr=its address in cycle N+1.
//   - Otherwise the block goes into the pending slot.
//   - If the slot is full, the block is dropped: not counted, acc_ptr does not increment, overrun=1.
// - While wr_req=1, wr_req and wr_addr hold stable until the cycle with wr_ack=1.
// - After an ack, a pending block is issued the next cycle (wr_req stays 1 back-to-back).
// - arm (IDLE/DONE):
//   - Latch pre_len and post_len; clear acq_done, overrun, trig_addr and the counters; set acc_ptr=0.
//   - Go to FILL, or straight to ARMED if pre_len=0. While busy=1, arm is ignored.
// - FILL: count accepted blocks. In the cycle the count reaches pre_len, go to ARMED.
//   - Trigger edges in FILL are ignored.
// - ARMED: blocks keep overwriting the ring.
//   - On a rising edge of acq_trig: trig_addr=acc_ptr, go to POST.
//   - A block accepted in the same cycle as the edge is post-block #1 and has address trig_addr.
//   - If post_len=0: go to DRAIN, and the block accepted in that cycle is not counted as a post block.
// - POST: count accepted blocks (including a same-cycle block from ARMED). The cycle the count equals
//   post_len -> DRAIN. No blocks are accepted after that.
// - DRAIN: accept nothing.
//   - Exit once wr_req=0 and the pending slot is empty: go to DONE with acq_done=1, or to IDLE if entered
//     via abort.
// - DONE: acq_done=1 and busy=0, until arm (-> new acquisition) or abort (-> IDLE, acq_done=0).
// - abort in FILL/ARMED/POST: the pending slot is discarded; an outstanding request is still held until
//   wr_ack; go to DRAIN, then to IDLE.
//   - abort together with arm: abort wins.
//   - abort in IDLE: no effect.
// - Edge detection keeps the previous acq_trig in a register (reset 0). A trigger held high across arm
//   does not fire until it goes low and then high again.
// TESTING
// - pre_len=4, post_len=3, blocks every 4 cycles, wr_ack 1 cycle after each wr_req; trigger after 6
//   blocks -> addresses 0..8, trig_addr=6, acq_done rises after the ack of address 8.
// - Trigger during FILL (after 2 of 4 blocks) -> stays in FILL, then ARMED after block 4; the next edge
//   gives trig_addr=4.
// - AW=3: 10 blocks in ARMED, then trigger, post_len=2 -> wr_addr sequence 0..7,0,1,2,3; trig_addr=2.
// - wr_ack held low for 10 cycles while blocks arrive every cycle -> first 2 stored (outstanding +
//   pending), the rest dropped, overrun=1; on ack the pending block issues the next cycle; overrun stays 1
//   until arm.
// - abort while ARMED with a request outstanding -> wr_req stays high until ack, pending block discarded,
//   state DRAIN -> IDLE, acq_done=0.
// - reset_n pulsed low mid-POST -> all outputs 0 immediately; a new arm then starts from wr_addr=0.

Source files
------------

// File: rtl/cbuf_acq_sequencer_if.sv
// DDR3 block write port between the acquisition sequencer (master) and the memory controller (slave).
interface cbuf_acq_sequencer_if #(
    parameter int unsigned AW = 20
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack;

    modport master (output wr_req, output wr_addr, input wr_ack);
    modport slave  (input wr_req, input wr_addr, output wr_ack);
endinterface

// File: rtl/cbuf_acq_sequencer.sv
// Circular-buffer acquisition sequencer: stores ADC blocks into a wrapping DDR3 ring with
// programmable pre-trigger fill and post-trigger length, then drains writes and flags completion.
module cbuf_acq_sequencer #(
    parameter int unsigned AW    = 20,
    parameter int unsigned LEN_W = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 acq_trig_i,
    input  logic [LEN_W-1:0]     pre_len_i,
    input  logic [LEN_W-1:0]     post_len_i,
    input  logic                 blk_valid_i,
    cbuf_acq_sequencer_if.master wr,
    output logic                 acq_done_o,
    output logic                 busy_o,
    output logic [AW-1:0]        trig_addr_o,
    output logic                 overrun_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_ptr_q, acc_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] pre_len_q, pre_len_d;
    logic [LEN_W-1:0] post_len_q, post_len_d;
    logic [AW-1:0]    trig_addr_q, trig_addr_d;
    logic             trig_prev_q, trig_prev_d;
    logic             overrun_q, overrun_d;
    logic             acq_done_q, acq_done_d;
    logic             busy_q, busy_d;
    logic             wr_req_q, wr_req_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic             pend_vld_q, pend_vld_d;
    logic [AW-1:0]    pend_addr_q, pend_addr_d;
    logic             aborted_q, aborted_d;

    logic             acq_state_c;
    logic             abort_c;
    logic             take_c;
    logic             store_c;
    logic             drop_c;
    logic             trig_edge_c;
    logic             req_free_c;
    logic [LEN_W-1:0] cnt_inc_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_ptr_q   <= '0;
            cnt_q       <= '0;
            pre_len_q   <= '0;
            post_len_q  <= '0;
            trig_addr_q <= '0;
            trig_prev_q <= 1'b0;
            overrun_q   <= 1'b0;
            acq_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_ptr_q   <= acc_ptr_d;
            cnt_q       <= cnt_d;
            pre_len_q   <= pre_len_d;
            post_len_q  <= post_len_d;
            trig_addr_q <= trig_addr_d;
            trig_prev_q <= trig_prev_d;
            overrun_q   <= overrun_d;
            acq_done_q  <= acq_done_d;
            busy_q      <= busy_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next-state: block acceptance, write path and acquisition sequencing
    always_comb begin
        state_d     = state_q;
        acc_ptr_d   = acc_ptr_q;
        cnt_d       = cnt_q;
        pre_len_d   = pre_len_q;
        post_len_d  = post_len_q;
        trig_addr_d = trig_addr_q;
        trig_prev_d = acq_trig_i;
        overrun_d   = overrun_q;
        acq_done_d  = acq_done_q;
        wr_req_d    = wr_req_q;
        wr_addr_d   = wr_addr_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        aborted_d   = aborted_q;

        acq_state_c = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
        abort_c     = abort_i && acq_state_c;
        take_c      = blk_valid_i && acq_state_c && !abort_i;
        store_c     = take_c && !pend_vld_q;
        drop_c      = take_c && pend_vld_q;
        trig_edge_c = acq_trig_i && !trig_prev_q;
        req_free_c  = !wr_req_q || wr.wr_ack;
        cnt_inc_c   = cnt_q + LEN_W'(1);

        // One outstanding request plus a single pending slot; abort discards the slot only
        if (wr_req_q && wr.wr_ack) begin
            wr_req_d = 1'b0;
        end
        if (abort_c) begin
            pend_vld_d = 1'b0;
        end else if (req_free_c && pend_vld_q) begin
            wr_req_d   = 1'b1;
            wr_addr_d  = pend_addr_q;
            pend_vld_d = 1'b0;
        end else if (store_c && req_free_c) begin
            wr_req_d  = 1'b1;
            wr_addr_d = acc_ptr_q;
        end else if (store_c) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = acc_ptr_q;
        end

        if (store_c) begin
            acc_ptr_d = acc_ptr_q + AW'(1);
        end
        if (drop_c) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort_i) begin
                    state_d    = S_IDLE;
                    acq_done_d = 1'b0;
                end else if (arm_i) begin
                    pre_len_d   = pre_len_i;
                    post_len_d  = post_len_i;
                    acq_done_d  = 1'b0;
                    overrun_d   = 1'b0;
                    trig_addr_d = '0;
                    cnt_d       = '0;
                    acc_ptr_d   = '0;
                    aborted_d   = 1'b0;
                    state_d     = (pre_len_i == '0) ? S_ARMED : S_FILL;
                end
            end
            S_FILL: begin
                if (abort_c) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (store_c) begin
                    if (cnt_inc_c == pre_len_q) begin
                        cnt_d   = '0;
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            S_ARMED: begin
                if (abort_c) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (trig_edge_c) begin
                    // A block stored on the trigger cycle is post-block #1 at trig_addr
                    trig_addr_d = acc_ptr_q;
                    cnt_d       = store_c ? LEN_W'(1) : '0;
                    if (post_len_q == '0) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else if (store_c && (post_len_q == LEN_W'(1))) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if (abort_c) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (store_c) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == post_len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!wr_req_q && !pend_vld_q) begin
                    if (aborted_q) begin
                        aborted_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        acq_done_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    assign wr.wr_req   = wr_req_q;
    assign wr.wr_addr  = wr_addr_q;
    assign acq_done_o  = acq_done_q;
    assign busy_o      = busy_q;
    assign trig_addr_o = trig_addr_q;
    assign overrun_o   = overrun_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cbuf_acq_sequencer.sv
// Scoreboard bench for cbuf_acq_sequencer on a small (AW=3) ring so address wrap is exercised.
module tb_cbuf_acq_sequencer;

    localparam int unsigned AW    = 3;
    localparam int unsigned LEN_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic             clk;
    logic             reset_n;
    logic             arm;
    logic             abort;
    logic             acq_trig;
    logic [LEN_W-1:0] pre_len;
    logic [LEN_W-1:0] post_len;
    logic             blk_valid;
    logic             acq_done;
    logic             busy;
    logic [AW-1:0]    trig_addr;
    logic             overrun;
    logic [2:0]       state;

    int unsigned      n_tests;
    int unsigned      n_fail;
    logic [AW-1:0]    exp_q[$];
    logic [AW-1:0]    exp_ptr;
    logic             ack_hold;
    int unsigned      ack_lat;

    cbuf_acq_sequencer_if #(.AW(AW)) wr_if ();

    cbuf_acq_sequencer #(.AW(AW), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .arm_i       (arm),
        .abort_i     (abort),
        .acq_trig_i  (acq_trig),
        .pre_len_i   (pre_len),
        .post_len_i  (post_len),
        .blk_valid_i (blk_valid),
        .wr          (wr_if),
        .acq_done_o  (acq_done),
        .busy_o      (busy),
        .trig_addr_o (trig_addr),
        .overrun_o   (overrun),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DDR3 model: acks after ack_lat cycles of wr_req, checks hold stability and scoreboard order
    initial begin : ddr_model
        int unsigned hi_cnt;
        logic        prev_held;
        logic [AW-1:0] prev_addr;
        hi_cnt       = 0;
        prev_held    = 1'b0;
        prev_addr    = '0;
        wr_if.wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_held && reset_n) begin
                check("wr_hold_req", 32'(wr_if.wr_req), 32'd1);
                check("wr_hold_addr", 32'(wr_if.wr_addr), 32'(prev_addr));
            end
            if (wr_if.wr_req && !ack_hold) begin
                hi_cnt++;
                if (hi_cnt >= ack_lat) begin
                    wr_if.wr_ack = 1'b1;
                    hi_cnt       = 0;
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 32'(wr_if.wr_addr), 32'hFFFF_FFFF);
                    end else begin
                        check("wr_addr", 32'(wr_if.wr_addr), 32'(exp_q.pop_front()));
                    end
                end else begin
                    wr_if.wr_ack = 1'b0;
                end
            end else begin
                wr_if.wr_ack = 1'b0;
                if (!wr_if.wr_req) hi_cnt = 0;
            end
            prev_held = wr_if.wr_req && !wr_if.wr_ack;
            prev_addr = wr_if.wr_addr;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm(input int pre, input int post);
        pre_len  = LEN_W'(pre);
        post_len = LEN_W'(post);
        arm      = 1'b1;
        exp_ptr  = '0;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic send_block(input bit stored, input bit with_trig, input int gap);
        blk_valid = 1'b1;
        acq_trig  = with_trig;
        if (stored) begin
            exp_q.push_back(exp_ptr);
            exp_ptr = exp_ptr + AW'(1);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        acq_trig  = 1'b0;
        tick(gap);
    endtask

    task automatic pulse_trig();
        acq_trig = 1'b1;
        @(negedge clk);
        acq_trig = 1'b0;
    endtask

    task automatic pulse_abort(input bit with_arm);
        abort = 1'b1;
        arm   = with_arm;
        @(negedge clk);
        abort = 1'b0;
        arm   = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    initial begin : stim
        n_tests   = 0;
        n_fail    = 0;
        ack_hold  = 1'b0;
        ack_lat   = 2;
        exp_ptr   = '0;
        reset_n   = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        acq_trig  = 1'b0;
        pre_len   = '0;
        post_len  = '0;
        blk_valid = 1'b0;
        #3;
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_outs", {25'd0, wr_if.wr_req, acq_done, busy, overrun, trig_addr}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Pre 4 / post 3, trigger after 6 blocks
        do_arm(4, 3);
        check("t1_fill", 32'(state), 32'(ST_FILL));
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_block(1'b1, 1'b0, 3);
        check("t1_armed", 32'(state), 32'(ST_ARMED));
        for (int i = 0; i < 2; i++) send_block(1'b1, 1'b0, 3);
        pulse_trig();
        check("t1_post", 32'(state), 32'(ST_POST));
        check("t1_trig_addr", 32'(trig_addr), 32'd6);
        for (int i = 0; i < 3; i++) send_block(1'b1, 1'b0, 3);
        wait_state("t1_done", ST_DONE, 20);
        check("t1_acq_done", 32'(acq_done), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Trigger during FILL is ignored
        do_arm(4, 1);
        check("t2_acq_done_clr", 32'(acq_done), 32'd0);
        check("t2_trig_clr", 32'(trig_addr), 32'd0);
        for (int i = 0; i < 2; i++) send_block(1'b1, 1'b0, 3);
        pulse_trig();
        tick(2);
        check("t2_fill_hold", 32'(state), 32'(ST_FILL));
        for (int i = 0; i < 2; i++) send_block(1'b1, 1'b0, 3);
        check("t2_armed", 32'(state), 32'(ST_ARMED));
        pulse_trig();
        check("t2_post", 32'(state), 32'(ST_POST));
        check("t2_trig_addr", 32'(trig_addr), 32'd4);
        send_block(1'b1, 1'b0, 3);
        wait_state("t2_done", ST_DONE, 20);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Ring wrap: 10 blocks in ARMED, trigger on the same cycle as block 11, post 2
        do_arm(0, 2);
        check("t3_armed", 32'(state), 32'(ST_ARMED));
        for (int i = 0; i < 10; i++) send_block(1'b1, 1'b0, 2);
        send_block(1'b1, 1'b1, 0);
        check("t3_post", 32'(state), 32'(ST_POST));
        check("t3_trig_addr", 32'(trig_addr), 32'd2);
        tick(2);
        send_block(1'b1, 1'b0, 0);
        wait_state("t3_done", ST_DONE, 20);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);
        pulse_abort(1'b0);
        check("t3_abort_done", 32'(state), 32'(ST_IDLE));
        check("t3_done_clr", 32'(acq_done), 32'd0);

        // Stalled DDR: outstanding + pending stored, the rest dropped
        do_arm(0, 3);
        ack_hold = 1'b1;
        for (int i = 0; i < 10; i++) send_block(i < 2, 1'b0, 0);
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_req_held", 32'(wr_if.wr_req), 32'd1);
        check("t4_addr_held", 32'(wr_if.wr_addr), 32'd0);
        ack_hold = 1'b0;
        tick(6);
        check("t4_q_drained", 32'(exp_q.size()), 32'd0);
        pulse_trig();
        check("t4_trig_addr", 32'(trig_addr), 32'd2);
        for (int i = 0; i < 3; i++) send_block(1'b1, 1'b0, 3);
        wait_state("t4_done", ST_DONE, 20);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);

        // Abort in ARMED with a request outstanding and a pending block
        do_arm(0, 3);
        check("t5_overrun_clr", 32'(overrun), 32'd0);
        ack_hold = 1'b1;
        send_block(1'b1, 1'b0, 0);
        send_block(1'b0, 1'b0, 0);
        pulse_abort(1'b0);
        check("t5_drain", 32'(state), 32'(ST_DRAIN));
        tick(3);
        check("t5_drain_hold", 32'(state), 32'(ST_DRAIN));
        check("t5_req_hold", 32'(wr_if.wr_req), 32'd1);
        ack_hold = 1'b0;
        wait_state("t5_idle", ST_IDLE, 20);
        check("t5_no_done", 32'(acq_done), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        tick(4);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);
        pulse_abort(1'b1);
        check("t5_abort_wins", 32'(state), 32'(ST_IDLE));

        // Asynchronous reset in the middle of POST
        do_arm(0, 5);
        for (int i = 0; i < 2; i++) send_block(1'b1, 1'b0, 3);
        pulse_trig();
        send_block(1'b1, 1'b0, 4);
        check("t6_post", 32'(state), 32'(ST_POST));
        check("t6_trig_addr", 32'(trig_addr), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(state), 32'(ST_IDLE));
        check("t6_rst_outs", {25'd0, wr_if.wr_req, acq_done, busy, overrun, trig_addr}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);
        do_arm(0, 1);
        pulse_trig();
        send_block(1'b1, 1'b0, 0);
        wait_state("t6_done", ST_DONE, 20);
        check("t6_trig_addr0", 32'(trig_addr), 32'd0);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
